// File: rtl/sram_track_player.sv
// ---------------------------------------------------------------------------
// sram_track_player
//
// Read side of the recorder's SRAM path. For each accepted sample request it
// reads track A, track B, or both from their SRAM regions, optionally
// averages the two, and presents one signed sample to the DAC-side converter.
// It keeps its own play position, which wraps at TRACK_LEN.
//
// Ports:
//   iCLK          system clock (CLOCK_50 domain)
//   iRST_N        synchronous active-low reset
//   iSAMPLE_REQ   one-cycle pulse per sample slot (already synchronized)
//   iPLAY         level; requests are accepted only when high
//   iMODE         00 track A, 01 track B, 10 mix A+B, 11 mute
//   iRESTART      one-cycle pulse returning the play position to 0
//   iSRAM_DQ      SRAM read data
//   oSRAM_ADDR    registered SRAM read address
//   oSRAM_OE_N    SRAM output enable, active low
//   oSAMPLE       registered signed output sample (held between updates)
//   oSAMPLE_VALID one-cycle pulse when oSAMPLE updates
//   oBUSY         high while the controller is not idle
//   oWRAP         pulse with oSAMPLE_VALID when the position wraps to 0
//   oOVERRUN      pulse when a request is dropped because the block is busy
// ---------------------------------------------------------------------------
module sram_track_player #(
  parameter int ADDR_W       = 18,
  parameter int DATA_W       = 16,
  parameter int TRACK_LEN    = 128000,
  parameter int TRACK_B_BASE = 128000
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iSAMPLE_REQ,
  input  logic              iPLAY,
  input  logic [1:0]        iMODE,
  input  logic              iRESTART,
  input  logic [DATA_W-1:0] iSRAM_DQ,
  output logic [ADDR_W-1:0] oSRAM_ADDR,
  output logic              oSRAM_OE_N,
  output logic [DATA_W-1:0] oSAMPLE,
  output logic              oSAMPLE_VALID,
  output logic              oBUSY,
  output logic              oWRAP,
  output logic              oOVERRUN
);

  typedef enum logic [1:0] {IDLE, RD_A, RD_B, OUT} state_t;

  localparam logic [1:0] MODE_A    = 2'b00;
  localparam logic [1:0] MODE_B    = 2'b01;
  localparam logic [1:0] MODE_MIX  = 2'b10;

  localparam logic [ADDR_W-1:0] B_BASE   = ADDR_W'(TRACK_B_BASE);
  localparam logic [ADDR_W-1:0] LAST_POS = ADDR_W'(TRACK_LEN - 1);

  state_t            state;
  logic [1:0]        mode_r;
  logic [ADDR_W-1:0] pos;
  logic [DATA_W-1:0] sa;
  logic [DATA_W-1:0] sb;
  logic              restart_seen;

  logic [ADDR_W-1:0] accept_pos;
  logic [DATA_W:0]   mix_sum;
  logic [DATA_W-1:0] result;

  // A restart coinciding with an accept must make that read use position 0,
  // so the address is taken from the post-restart position rather than pos.
  assign accept_pos = iRESTART ? '0 : pos;

  // Sign-extend both samples by one bit before adding so the sum never
  // overflows; dropping the LSB is then an arithmetic (floor) divide by two.
  assign mix_sum = {sa[DATA_W-1], sa} + {sb[DATA_W-1], sb};

  // Output sample selection for the mode latched at accept time.
  always_comb begin
    result = '0;
    case (mode_r)
      MODE_A:   result = sa;
      MODE_B:   result = sb;
      MODE_MIX: result = mix_sum[DATA_W:1];
      default:  result = '0;
    endcase
  end

  // Single FSM with all outputs registered. oBUSY is loaded with
  // (next state != IDLE) in every branch so it is a clean register output.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state         <= IDLE;
      mode_r        <= MODE_A;
      pos           <= '0;
      sa            <= '0;
      sb            <= '0;
      restart_seen  <= 1'b0;
      oSRAM_ADDR    <= '0;
      oSRAM_OE_N    <= 1'b1;
      oSAMPLE       <= '0;
      oSAMPLE_VALID <= 1'b0;
      oBUSY         <= 1'b0;
      oWRAP         <= 1'b0;
      oOVERRUN      <= 1'b0;
    end else begin
      oSAMPLE_VALID <= 1'b0;
      oWRAP         <= 1'b0;
      // Any request arriving outside IDLE (including the OUT cycle) is dropped.
      oOVERRUN      <= iSAMPLE_REQ && (state != IDLE);

      case (state)
        IDLE: begin
          if (iRESTART) begin
            pos <= '0;
          end
          if (iSAMPLE_REQ && iPLAY) begin
            mode_r       <= iMODE;
            restart_seen <= 1'b0;
            oBUSY        <= 1'b1;
            case (iMODE)
              MODE_A, MODE_MIX: begin
                oSRAM_ADDR <= accept_pos;
                oSRAM_OE_N <= 1'b0;
                state      <= RD_A;
              end
              MODE_B: begin
                oSRAM_ADDR <= B_BASE + accept_pos;
                oSRAM_OE_N <= 1'b0;
                state      <= RD_B;
              end
              default: begin
                state <= OUT;
              end
            endcase
          end else begin
            oBUSY <= 1'b0;
          end
        end

        RD_A: begin
          if (iRESTART) begin
            restart_seen <= 1'b1;
          end
          sa    <= iSRAM_DQ;
          oBUSY <= 1'b1;
          if (mode_r == MODE_MIX) begin
            oSRAM_ADDR <= B_BASE + pos;
            state      <= RD_B;
          end else begin
            oSRAM_OE_N <= 1'b1;
            state      <= OUT;
          end
        end

        RD_B: begin
          if (iRESTART) begin
            restart_seen <= 1'b1;
          end
          sb         <= iSRAM_DQ;
          oSRAM_OE_N <= 1'b1;
          oBUSY      <= 1'b1;
          state      <= OUT;
        end

        OUT: begin
          oSAMPLE       <= result;
          oSAMPLE_VALID <= 1'b1;
          oBUSY         <= 1'b0;
          state         <= IDLE;
          // A restart seen anywhere in this transaction wins over a wrap,
          // and suppresses the wrap pulse.
          if (restart_seen || iRESTART) begin
            pos <= '0;
          end else if (pos == LAST_POS) begin
            pos   <= '0;
            oWRAP <= 1'b1;
          end else begin
            pos <= pos + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          oBUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sram_track_player.md
Name: sram_track_player

Overview:
- Playback and mix reader for audio tracks stored in SRAM by the recorder path. It is the read side of the recorder's SRAM write path.
- On each sample request it reads track A, track B, or both from the two SRAM track regions, then optionally averages them.
- It presents one 16-bit signed sample to the DAC-side audio converter.
- It keeps its own play position, which wraps at the track length.

Parameters:
- ADDR_W, 18, SRAM address width.
- DATA_W, 16, sample and SRAM data width.
- TRACK_LEN, 128000, samples per track. Positions run 0..TRACK_LEN-1.
- TRACK_B_BASE, 128000, SRAM base address of track B. Track A base is 0.

Ports:
- iCLK  input  1  system clock (CLOCK_50 domain).
- iRST_N  input  1  reset, synchronous, active-low.
- iSAMPLE_REQ  input  1  one-cycle pulse per sample slot (LRCK edge already synchronized to iCLK).
- iPLAY  input  1  level; requests are accepted only when high.
- iMODE  input  2  00 track A, 01 track B, 10 mix A+B, 11 mute.
- iRESTART  input  1  one-cycle pulse; returns the position to 0.
- iSRAM_DQ  input  DATA_W  SRAM read data.
- oSRAM_ADDR  output  ADDR_W  registered SRAM read address.
- oSRAM_OE_N  output  1  SRAM output enable, active low.
- oSAMPLE  output  DATA_W  registered output sample, signed.
- oSAMPLE_VALID  output  1  one-cycle pulse when oSAMPLE updates.
- oBUSY  output  1  high while state is not IDLE.
- oWRAP  output  1  one-cycle pulse, coincident with oSAMPLE_VALID, when the position wraps to 0.
- oOVERRUN  output  1  one-cycle pulse when a request is dropped because the block is busy.

Behaviour:
- Reset (iRST_N low at an edge):
  - state IDLE, pos 0.
  - oSRAM_ADDR 0, oSRAM_OE_N 1, oSAMPLE 0.
  - oSAMPLE_VALID, oBUSY, oWRAP, oOVERRUN all 0.
  - Reset overrides any in-flight read; no valid pulse is produced for that read.
- States: IDLE, RD_A, RD_B, OUT.
- IDLE, with iSAMPLE_REQ and iPLAY high at edge t:
  - iMODE is latched into mode_r. Later changes to iMODE are ignored until the next accept.
  - Mode 00 or 10: oSRAM_ADDR <= pos, go to RD_A.
  - Mode 01: oSRAM_ADDR <= TRACK_B_BASE+pos, go to RD_B.
  - Mode 11: go to OUT.
  - oSRAM_OE_N <= 0 for the read modes.
- A request with iPLAY low is ignored: no state change, no overrun pulse.
- RD_A: capture sa <= iSRAM_DQ.
  - Mode 10: oSRAM_ADDR <= TRACK_B_BASE+pos, go to RD_B.
  - Otherwise: oSRAM_OE_N <= 1, go to OUT.
- RD_B: capture sb <= iSRAM_DQ, oSRAM_OE_N <= 1, go to OUT.
- OUT: oSAMPLE <= result, oSAMPLE_VALID <= 1, advance the position, go to IDLE.
  - Mode 00: result = sa.
  - Mode 01: result = sb.
  - Mode 11: result = 0.
  - Mode 10: result = (sext17(sa)+sext17(sb)) >>> 1, arithmetic, i.e. floor. No overflow is possible.
- Latency from the accepting edge t: oSAMPLE_VALID high after edge t+3 (mix), t+2 (A or B), t+1 (mute).
- Position advance, applied in OUT:
  - If iRESTART was seen since accept, or is high in OUT: pos <= 0, oWRAP stays 0.
  - Else if pos == TRACK_LEN-1: pos <= 0, oWRAP <= 1.
  - Else pos <= pos+1.
- iRESTART in IDLE sets pos <= 0 on that edge. If it coincides with an accept, the read uses pos 0.
- iSAMPLE_REQ while state is not IDLE: the request is dropped and oOVERRUN pulses for one cycle. The in-flight read is unaffected.
- A request in the same cycle as OUT is dropped (state not IDLE).
- Mute also advances pos, so the tracks stay aligned.
- oSAMPLE holds its value between valid pulses.
- oBUSY is registered and equals (next state != IDLE).

Test Plan:
- Mix, pos 0, A[0]=0x1000, B[128000]=0x3000, request at edge t → oSRAM_ADDR=0 after t, 128000 after t+1; oSAMPLE=0x2000 with valid after t+3; pos becomes 1.
- Mix arithmetic:
  - 0x7FFF+0x7FFF → 0x7FFF
  - 0x8000+0x8000 → 0x8000
  - 0xFFFF+0x0000 → 0xFFFF
  - 0x0003+0x0000 → 0x0001
  - 0x8000+0x7FFF → 0xFFFF
- Wrap with TRACK_LEN=4, mode 00, 5 requests → addresses 0,1,2,3,0; oWRAP on the 4th valid only. iRESTART mid-read at pos 2 → next address 0, no oWRAP.
- Mode 01 → valid after t+2 with data from TRACK_B_BASE+pos. Mode 11 → valid after t+1 with oSAMPLE=0 and no OE_N assertion. iMODE toggled during RD_A → result follows the latched mode.
- Request during RD_B → one oOVERRUN pulse, exactly one valid. iPLAY=0 with a request → no activity, pos unchanged.
- iRST_N low during RD_B → all outputs at reset values after that edge, no valid. Next request reads address 0.
